even_seq_checker: RTL and testbench

- Receiver-side checker for the even-number sequence generator: samples the generator output stream and confirms it follows 0, 2, 4, …, 2^WIDTH-2, 0, … with wrap.
- Hunts for alignment, locks after LOCK_COUNT consecutive correct samples, flags mismatches and counts them.
- Sits directly on the generator's output bus, as the self-check and monitor for the generator path.

---
 rtl/even_seq_checker_pkg.sv | 15 +
 rtl/even_seq_checker_dfar.sv | 19 +
 rtl/even_seq_checker.sv | 121 ++++++++++++
 tb/tb_even_seq_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/even_seq_checker_pkg.sv
// Shared types and constants for the even-number sequence checker.
package even_seq_checker_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam int unsigned STATE_W  = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned ERRC_W   = 8;
    localparam int unsigned SEQ_STEP = 2;

endpackage : even_seq_checker_pkg

// File: rtl/even_seq_checker_dfar.sv
// D register with asynchronous active-high reset to zero.
module dfar #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= in;
        end
    end

endmodule : dfar

// File: rtl/even_seq_checker.sv
// Monitors a 0,2,4,... generator stream: hunts, locks, flags and counts mismatches.
module even_seq_checker
    import even_seq_checker_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_LIMIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [WIDTH-1:0]  data,
    output logic              locked,
    output logic              err,
    output logic              odd_seen,
    output logic [WIDTH-1:0]  expected,
    output logic [ERRC_W-1:0] err_count
);

    logic [STATE_W-1:0] state_raw;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic [ERRC_W-1:0]  err_count_q, err_count_d;
    logic               locked_q, locked_d;
    logic               err_q, err_d;
    logic               odd_q, odd_d;
    logic [WIDTH-1:0]   data_next;
    logic [WIDTH-1:0]   expected_next;

    assign state_q       = state_e'(state_raw);
    assign data_next     = data + WIDTH'(SEQ_STEP);
    assign expected_next = expected_q + WIDTH'(SEQ_STEP);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_count_d = err_count_q;
        locked_d    = locked_q;
        err_d       = 1'b0;
        odd_d       = 1'b0;

        if (valid) begin
            odd_d = data[0];
        end

        case (state_q)
            HUNT: begin
                if (valid && !data[0]) begin
                    expected_d = data_next;
                    match_d    = CNT_W'(1);
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                if (valid) begin
                    if (data == expected_q) begin
                        expected_d = expected_next;
                        match_d    = match_q + CNT_W'(1);
                        if (match_d == CNT_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                        end
                    end else if (!data[0]) begin
                        expected_d = data_next;
                        match_d    = CNT_W'(1);
                    end else begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (valid) begin
                    // Expected value freewheels on a miss so a single glitch re-aligns.
                    expected_d = expected_next;
                    if (data == expected_q) begin
                        miss_d = '0;
                    end else begin
                        err_d  = 1'b1;
                        miss_d = miss_q + CNT_W'(1);
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERRC_W'(1);
                        end
                        if (miss_d == CNT_W'(ERR_LIMIT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d  = HUNT;
                locked_d = 1'b0;
                match_d  = '0;
                miss_d   = '0;
            end
        endcase
    end

    dfar #(.WIDTH(STATE_W)) u_state     (.clk(clk), .reset(reset), .in(state_d),     .out(state_raw));
    dfar #(.WIDTH(WIDTH))   u_expected  (.clk(clk), .reset(reset), .in(expected_d),  .out(expected_q));
    dfar #(.WIDTH(CNT_W))   u_match     (.clk(clk), .reset(reset), .in(match_d),     .out(match_q));
    dfar #(.WIDTH(CNT_W))   u_miss      (.clk(clk), .reset(reset), .in(miss_d),      .out(miss_q));
    dfar #(.WIDTH(ERRC_W))  u_err_count (.clk(clk), .reset(reset), .in(err_count_d), .out(err_count_q));
    dfar #(.WIDTH(1))       u_locked    (.clk(clk), .reset(reset), .in(locked_d),    .out(locked_q));
    dfar #(.WIDTH(1))       u_err       (.clk(clk), .reset(reset), .in(err_d),       .out(err_q));
    dfar #(.WIDTH(1))       u_odd       (.clk(clk), .reset(reset), .in(odd_d),       .out(odd_q));

    assign locked    = locked_q;
    assign err       = err_q;
    assign odd_seen  = odd_q;
    assign expected  = expected_q;
    assign err_count = err_count_q;

endmodule : even_seq_checker

// File: tb/tb_even_seq_checker.sv
// Self-checking bench for even_seq_checker against a rule-level reference model.
module tb_even_seq_checker;

    localparam int unsigned WIDTH      = 4;
    localparam int unsigned LOCK_COUNT = 3;
    localparam int unsigned ERR_LIMIT  = 2;
    localparam int          MOD        = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             locked;
    logic             err;
    logic             odd_seen;
    logic [WIDTH-1:0] expected;
    logic [7:0]       err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=hunting, 1=syncing, 2=locked
    int m_mode, m_exp, m_match, m_miss, m_cnt;
    bit m_err, m_odd, m_locked;

    even_seq_checker #(
        .WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .data(data),
        .locked(locked), .err(err), .odd_seen(odd_seen),
        .expected(expected), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0; m_cnt = 0;
        m_err = 0; m_odd = 0; m_locked = 0;
    endfunction

    function automatic void model_step(bit v, int d);
        m_err = 0;
        m_odd = 0;
        if (!v) return;
        m_odd = d[0];
        case (m_mode)
            0: if (d % 2 == 0) begin
                m_exp = (d + 2) % MOD; m_match = 1; m_mode = 1;
            end
            1: if (d == m_exp) begin
                m_exp = (m_exp + 2) % MOD; m_match++;
                if (m_match == LOCK_COUNT) m_mode = 2;
            end else if (d % 2 == 0) begin
                m_exp = (d + 2) % MOD; m_match = 1;
            end else begin
                m_mode = 0; m_match = 0;
            end
            default: begin
                if (d != m_exp) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_miss++;
                    if (m_miss == ERR_LIMIT) begin
                        m_mode = 0; m_miss = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_exp = (m_exp + 2) % MOD;
            end
        endcase
        m_locked = (m_mode == 2);
    endfunction

    // Drive one cycle, advance the model at the edge, sample 1 time unit later.
    task automatic step(input bit v, input int d);
        valid = v;
        data  = WIDTH'(d);
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        if ({locked, err, odd_seen, expected, err_count} !== {1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got locked=%b err=%b odd=%b exp=%0d cnt=%0d, want all zero",
                     locked, err, odd_seen, expected, err_count);
        end
        n_tests++;
    endtask

    task automatic test_lock();
        int seq[3] = '{0, 2, 4};
        for (int i = 0; i < 3; i++) begin
            step(1, seq[i]);
            if ({locked, err, odd_seen, expected, err_count} !==
                {m_locked, m_err, m_odd, WIDTH'(m_exp), 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL lock[%0d]: got l=%b e=%b o=%b x=%0d c=%0d want l=%b e=%b o=%b x=%0d c=%0d",
                         i, locked, err, odd_seen, expected, err_count,
                         m_locked, m_err, m_odd, m_exp, m_cnt);
            end
            n_tests++;
        end
        if (!(locked === 1'b1 && expected === 4'd6 && err === 1'b0 && err_count === 8'd0)) begin
            n_fail++;
            $display("FAIL lock_final: got l=%b x=%0d e=%b c=%0d want l=1 x=6 e=0 c=0",
                     locked, expected, err, err_count);
        end
        n_tests++;
    endtask

    task automatic test_wrap();
        int seq[7] = '{6, 8, 10, 12, 14, 0, 2};
        for (int i = 0; i < 7; i++) begin
            step(1, seq[i]);
            if ({locked, err, expected} !== {m_locked, m_err, WIDTH'(m_exp)}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got l=%b e=%b x=%0d want l=%b e=%b x=%0d",
                         i, locked, err, expected, m_locked, m_err, m_exp);
            end
            n_tests++;
        end
        if (!(expected === 4'd4 && locked === 1'b1)) begin
            n_fail++;
            $display("FAIL wrap_final: got x=%0d l=%b want x=4 l=1", expected, locked);
        end
        n_tests++;
    endtask

    task automatic test_err_path();
        do_reset();
        step(1, 0); step(1, 2); step(1, 4);
        step(1, 9);
        if (!(err === 1'b1 && odd_seen === 1'b1 && err_count === 8'd1 && expected === 4'd8 && locked === 1'b1)) begin
            n_fail++;
            $display("FAIL odd_in_lock: got e=%b o=%b c=%0d x=%0d l=%b want e=1 o=1 c=1 x=8 l=1",
                     err, odd_seen, err_count, expected, locked);
        end
        n_tests++;
        step(1, 3);
        if (!(err === 1'b1 && err_count === 8'd2 && locked === 1'b0)) begin
            n_fail++;
            $display("FAIL err_limit: got e=%b c=%0d l=%b want e=1 c=2 l=0", err, err_count, locked);
        end
        n_tests++;
        step(0, 0);
        if (!(err === 1'b0 && odd_seen === 1'b0)) begin
            n_fail++;
            $display("FAIL pulse_clear: got e=%b o=%b want 0 0", err, odd_seen);
        end
        n_tests++;
    endtask

    task automatic test_reseed();
        do_reset();
        step(1, 2); step(1, 4);
        step(1, 10);
        if (!(expected === 4'd12 && err === 1'b0 && locked === 1'b0)) begin
            n_fail++;
            $display("FAIL reseed: got x=%0d e=%b l=%b want x=12 e=0 l=0", expected, err, locked);
        end
        n_tests++;
        step(1, 12);
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reseed_early_lock: got l=%b want 0", locked);
        end
        n_tests++;
        step(1, 14);
        if (!(locked === 1'b1 && expected === 4'd0)) begin
            n_fail++;
            $display("FAIL reseed_lock: got l=%b x=%0d want l=1 x=0", locked, expected);
        end
        n_tests++;
    endtask

    task automatic test_valid_gap();
        do_reset();
        step(1, 0); step(1, 2); step(1, 4);
        for (int i = 0; i < 5; i++) begin
            step(0, 7);
            if ({locked, err, odd_seen, expected} !== {1'b1, 1'b0, 1'b0, 4'd6}) begin
                n_fail++;
                $display("FAIL valid_gap[%0d]: got l=%b e=%b o=%b x=%0d want l=1 e=0 o=0 x=6",
                         i, locked, err, odd_seen, expected);
            end
            n_tests++;
        end
        step(1, 6);
        if ({locked, err, expected} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL gap_resume: got l=%b e=%b x=%0d want l=1 e=0 x=8", locked, err, expected);
        end
        n_tests++;
    endtask

    task automatic test_async_reset();
        step(1, 2);
        step(1, 8);
        #3;
        reset = 1'b1;
        #1;
        if ({locked, err, expected, err_count} !== {1'b0, 1'b0, 4'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got l=%b e=%b x=%0d c=%0d want all zero",
                     locked, err, expected, err_count);
        end
        n_tests++;
        model_reset();
        #3;
        reset = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #1;
        step(1, 4);
        if ({locked, expected} !== {1'b0, 4'd6}) begin
            n_fail++;
            $display("FAIL post_reset_hunt: got l=%b x=%0d want l=0 x=6", locked, expected);
        end
        n_tests++;
    endtask

    task automatic test_saturation();
        int guard = 0;
        do_reset();
        while (m_cnt < 255 && guard < 400) begin
            step(1, 0); step(1, 2); step(1, 4);
            step(1, 10); step(1, 10);
            guard++;
        end
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_reach: got c=%0d want 255", err_count);
        end
        n_tests++;
        step(1, 0); step(1, 2); step(1, 4);
        step(1, 12);
        if (!(err === 1'b1 && err_count === 8'd255)) begin
            n_fail++;
            $display("FAIL sat_hold: got e=%b c=%0d want e=1 c=255", err, err_count);
        end
        n_tests++;
    endtask

    task automatic test_random();
        int d;
        bit v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) d = int'($urandom_range(0, MOD - 1));
            else d = m_exp;
            step(v, d);
            if ({locked, err, odd_seen, expected, err_count} !==
                {m_locked, m_err, m_odd, WIDTH'(m_exp), 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL random[%0d]: v=%b d=%0d got l=%b e=%b o=%b x=%0d c=%0d want l=%b e=%b o=%b x=%0d c=%0d",
                         i, v, d, locked, err, odd_seen, expected, err_count,
                         m_locked, m_err, m_odd, m_exp, m_cnt);
            end
            n_tests++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_err_path();
        test_reseed();
        test_valid_gap();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_even_seq_checker
